// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with start/done handshake, carry-out and signed overflow.
module serial_addsub #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             k,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] dig_ext;
  logic             cin_msb;
  logic             last_step;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             c);
    return {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, c};
  endfunction

  // Carry into the top bit of a digit is recovered from that bit's own sum.
  function automatic logic carry_into_msb(input logic [DIGIT:0]   sm,
                                          input logic [DIGIT-1:0] a,
                                          input logic [DIGIT-1:0] b);
    return sm[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
  endfunction

  always_comb begin
    sum       = digit_add(opa_q[DIGIT-1:0], opb_q[DIGIT-1:0], carry_q);
    cin_msb   = carry_into_msb(sum, opa_q[DIGIT-1:0], opb_q[DIGIT-1:0]);
    dig_ext   = WIDTH'(sum[DIGIT-1:0]);
    last_step = (cnt_q == CNT_W'(STEPS - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          opa_d   = x;
          opb_d   = y ^ {WIDTH{k}};
          carry_d = k;
          cnt_d   = '0;
          s_d     = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d     = (s_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = DONE;
          cout_d  = sum[DIGIT];
          ovf_d   = cin_msb ^ sum[DIGIT];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architecturally visible results: reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand datapath: always reloaded on an accepted start, no reset needed.
  always_ff @(posedge clk) begin
    opa_q   <= opa_d;
    opb_q   <= opb_d;
    carry_q <= carry_d;
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
